dx_pipe_reg: RTL and testbench

Decode-to-Execute pipeline register for the 4-stage RISC-V core (F, D, X, M/WB). It captures the decoded instruction, PC and register-file operands into the X stage, and it produces the `inst_X` consumed by the X-stage operand selectors. It also runs the load-interlock state machine, which covers the cases MEM forwarding in X does not handle (branch operands and store base address): it stalls D for one cycle, injects a bubble into X, and bypasses write-back data into the captured operands. It also flushes X on a redirect and counts inserted bubbles.

---
 rtl/dx_pipe_reg_pkg.sv | 23 ++
 rtl/dx_hazard_detect.sv | 45 ++++
 rtl/dx_pipe_reg.sv | 105 ++++++++++
 tb/tb_dx_pipe_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dx_pipe_reg_pkg.sv
// dx_pipe_reg_pkg
//   Shared constants for the Decode-to-Execute pipeline register:
//   - RV32I major opcodes that the load interlock looks at.
//   - The x0 register index.
//   - The default bubble instruction.
//   - The interlock FSM state encoding.
package dx_pipe_reg_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] REG_X0 = 5'd0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } dx_state_e;

endpackage

// File: rtl/dx_hazard_detect.sv
// dx_hazard_detect
//   Combinational load-use detector. It flags the cases that X-stage MEM
//   forwarding cannot cover: a valid load in X whose destination is used by
//   the instruction in D as
//   - a branch operand (rs1 or rs2), or
//   - a store base address (rs1 only).
//   Ports:
//     inst_D, valid_D : instruction in D and its valid bit
//     inst_X, valid_X : instruction in X and its valid bit
//     hazard          : interlock required this cycle
module dx_hazard_detect
  import dx_pipe_reg_pkg::*;
(
  input  logic [31:0] inst_D,
  input  logic        valid_D,
  input  logic [31:0] inst_X,
  input  logic        valid_X,
  output logic        hazard
);

  logic [4:0] rd_X;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       load_X;
  logic       branch_use;
  logic       store_use;

  assign rd_X  = inst_X[11:7];
  assign rs1_D = inst_D[19:15];
  assign rs2_D = inst_D[24:20];

  assign load_X = valid_X && (inst_X[6:0] == OPC_LOAD) && (rd_X != REG_X0);

  assign branch_use = (inst_D[6:0] == OPC_BRANCH) && ((rd_X == rs1_D) || (rd_X == rs2_D));

  // The store data operand (rs2) is forwarded in X; only the base address matters.
  assign store_use = (inst_D[6:0] == OPC_STORE) && (rd_X == rs1_D);

  assign hazard = load_X && valid_D && (branch_use || store_use);

  // Fields that take no part in the decision.
  logic unused_fields;
  assign unused_fields = &{1'b0, inst_X[31:12], inst_D[14:7], inst_D[31:25]};

endmodule

// File: rtl/dx_pipe_reg.sv
// dx_pipe_reg
//   D->X pipeline register with a load interlock.
//   A load in X feeding a branch or a store base in D causes the following:
//   - D is stalled for one cycle.
//   - A bubble is injected into X.
//   - Write-back data is bypassed into the operands captured when D advances.
//   A redirect resolved in X flushes X with a bubble. Interlock bubbles are
//   counted; redirect bubbles are not.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     inst_D, pc_D, valid_D            : instruction in D
//     rs1_data_D, rs2_data_D           : register-file read data for inst_D
//     redirect_X                       : taken branch/jump in X, kill younger
//     wb_we, wb_rd, wb_data            : write-back from M this cycle
//     inst_X, pc_X, valid_X            : X-stage registers
//     rs1_data_X, rs2_data_X           : X-stage operands
//     stall_D                          : hold F/D and PC (combinational)
//     bubble_count                     : interlock bubbles since reset
module dx_pipe_reg
  import dx_pipe_reg_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_D,
  input  logic [31:0] pc_D,
  input  logic [31:0] rs1_data_D,
  input  logic [31:0] rs2_data_D,
  input  logic        valid_D,
  input  logic        redirect_X,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] inst_X,
  output logic [31:0] pc_X,
  output logic [31:0] rs1_data_X,
  output logic [31:0] rs2_data_X,
  output logic        valid_X,
  output logic        stall_D,
  output logic [31:0] bubble_count
);

  dx_state_e state;
  logic      hazard;

  dx_hazard_detect u_hazard_detect (
    .inst_D  (inst_D),
    .valid_D (valid_D),
    .inst_X  (inst_X),
    .valid_X (valid_X),
    .hazard  (hazard)
  );

  // HOLD never stalls: the bubble is already in X and D must advance.
  assign stall_D = (state == RUN) && hazard && !redirect_X;

  // Operand selection at capture. x0 reads as zero regardless of the
  // register file or a write-back that names x0.
  function automatic logic [31:0] bypass_operand(
    input logic [4:0]  src_sel,
    input logic [31:0] rf_val,
    input logic        wr_en,
    input logic [4:0]  wr_sel,
    input logic [31:0] wr_val
  );
    if (src_sel == REG_X0)
      return 32'h0;
    else if (wr_en && (wr_sel == src_sel))
      return wr_val;
    else
      return rf_val;
  endfunction

  // D -> X stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      inst_X       <= NOP_INST;
      pc_X         <= RESET_PC;
      rs1_data_X   <= 32'h0;
      rs2_data_X   <= 32'h0;
      valid_X      <= 1'b0;
      bubble_count <= 32'h0;
    end else begin
      state <= stall_D ? HOLD : RUN;
      if (redirect_X) begin
        inst_X  <= NOP_INST;
        valid_X <= 1'b0;
      end else if (stall_D) begin
        inst_X       <= NOP_INST;
        valid_X      <= 1'b0;
        bubble_count <= bubble_count + 32'd1;
      end else begin
        inst_X     <= inst_D;
        pc_X       <= pc_D;
        valid_X    <= valid_D;
        rs1_data_X <= bypass_operand(inst_D[19:15], rs1_data_D, wb_we, wb_rd, wb_data);
        rs2_data_X <= bypass_operand(inst_D[24:20], rs2_data_D, wb_we, wb_rd, wb_data);
      end
    end
  end

endmodule

// File: tb/tb_dx_pipe_reg.sv
// tb_dx_pipe_reg
//   Directed bench for dx_pipe_reg. Inputs change 1 time unit after the
//   rising edge; registered outputs are sampled there and stall_D 1 unit
//   after the inputs settle.
module tb_dx_pipe_reg;
  import dx_pipe_reg_pkg::*;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_2000;
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X7    = 32'h0000_A383; // lw   x7,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] BEQ_5_6  = 32'h0062_8063; // beq  x5,x6,0
  localparam logic [31:0] BEQ_0_0  = 32'h0000_0063; // beq  x0,x0,0
  localparam logic [31:0] SW_1_7   = 32'h0013_A023; // sw   x1,0(x7)
  localparam logic [31:0] SW_7_1   = 32'h0070_A023; // sw   x7,0(x1)
  localparam logic [31:0] ADD_3_56 = 32'h0062_81B3; // add  x3,x5,x6

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_D, pc_D, rs1_data_D, rs2_data_D, wb_data;
  logic        valid_D, redirect_X, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] inst_X, pc_X, rs1_data_X, rs2_data_X, bubble_count;
  logic        valid_X, stall_D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dx_pipe_reg #(
    .NOP_INST (NOP),
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_D       (inst_D),
    .pc_D         (pc_D),
    .rs1_data_D   (rs1_data_D),
    .rs2_data_D   (rs2_data_D),
    .valid_D      (valid_D),
    .redirect_X   (redirect_X),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .inst_X       (inst_X),
    .pc_X         (pc_X),
    .rs1_data_X   (rs1_data_X),
    .rs2_data_X   (rs2_data_X),
    .valid_X      (valid_X),
    .stall_D      (stall_D),
    .bubble_count (bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inst_D = NOP; pc_D = 32'h0; rs1_data_D = 32'h0; rs2_data_D = 32'h0;
    valid_D = 1'b0; redirect_X = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_inst_X", inst_X, NOP);
    chk("rst_pc_X", pc_X, RST_PC);
    chk("rst_valid_X", 32'(valid_X), 32'd0);
    chk("rst_bubble_count", bubble_count, 32'd0);
    chk("rst_stall_D", 32'(stall_D), 32'd0);
    chk("rst_rs1_data_X", rs1_data_X, 32'd0);
    rst = 1'b0;

    // Load x5 then dependent beq x5,x6 with WB bypass at n+1
    inst_D = LW_X5; pc_D = 32'h100; valid_D = 1'b1;
    tick();
    chk("ld_inst_X", inst_X, LW_X5);
    chk("ld_pc_X", pc_X, 32'h100);
    chk("ld_valid_X", 32'(valid_X), 32'd1);
    inst_D = BEQ_5_6; pc_D = 32'h104; rs1_data_D = 32'hDEAD_BEEF; rs2_data_D = 32'h66;
    #1 chk("beq_stall_n", 32'(stall_D), 32'd1);
    tick();
    chk("beq_bubble_inst", inst_X, NOP);
    chk("beq_bubble_valid", 32'(valid_X), 32'd0);
    chk("beq_bubble_pc_hold", pc_X, 32'h100);
    chk("beq_count", bubble_count, 32'd1);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    #1 chk("beq_stall_n1", 32'(stall_D), 32'd0);
    tick();
    chk("beq_inst_X", inst_X, BEQ_5_6);
    chk("beq_pc_X", pc_X, 32'h104);
    chk("beq_rs1_bypass", rs1_data_X, 32'h1234);
    chk("beq_rs2_rf", rs2_data_X, 32'h66);
    chk("beq_valid_X", 32'(valid_X), 32'd1);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    // Load x7 then sw x1,0(x7): base dependency interlocks
    inst_D = LW_X7; pc_D = 32'h200;
    tick();
    inst_D = SW_1_7; pc_D = 32'h204;
    #1 chk("sw_base_stall", 32'(stall_D), 32'd1);
    tick();
    chk("sw_base_bubble", inst_X, NOP);
    chk("sw_base_count", bubble_count, 32'd2);
    tick();
    chk("sw_base_inst_X", inst_X, SW_1_7);

    // Load x7 then sw x7,0(x1): data dependency only, no stall
    inst_D = LW_X7; pc_D = 32'h300;
    tick();
    inst_D = SW_7_1; pc_D = 32'h304;
    #1 chk("sw_data_stall", 32'(stall_D), 32'd0);
    tick();
    chk("sw_data_inst_X", inst_X, SW_7_1);
    chk("sw_data_count", bubble_count, 32'd2);

    // Load x5 then ALU consumer: no interlock
    inst_D = LW_X5; pc_D = 32'h400;
    tick();
    inst_D = ADD_3_56; pc_D = 32'h404;
    #1 chk("alu_stall", 32'(stall_D), 32'd0);
    tick();
    chk("alu_inst_X", inst_X, ADD_3_56);

    // Load x0 then beq x0,x0: no stall, x0 ignores a WB naming x0
    inst_D = LW_X0; pc_D = 32'h500; rs1_data_D = 32'h0; rs2_data_D = 32'h0;
    tick();
    inst_D = BEQ_0_0; pc_D = 32'h504;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1 chk("x0_stall", 32'(stall_D), 32'd0);
    tick();
    chk("x0_inst_X", inst_X, BEQ_0_0);
    chk("x0_rs1_data_X", rs1_data_X, 32'h0);
    chk("x0_rs2_data_X", rs2_data_X, 32'h0);
    wb_we = 1'b0; wb_data = 32'h0;

    // Hazard and redirect together: redirect wins
    inst_D = LW_X5; pc_D = 32'h600;
    tick();
    inst_D = BEQ_5_6; pc_D = 32'h604; redirect_X = 1'b1;
    #1 chk("redir_stall", 32'(stall_D), 32'd0);
    tick();
    chk("redir_inst_X", inst_X, NOP);
    chk("redir_valid_X", 32'(valid_X), 32'd0);
    chk("redir_pc_hold", pc_X, 32'h600);
    chk("redir_count", bubble_count, 32'd2);
    chk("redir_state", 32'(dut.state), 32'(RUN));
    redirect_X = 1'b0;

    // Reset while in HOLD
    inst_D = LW_X5; pc_D = 32'h700;
    tick();
    inst_D = BEQ_5_6; pc_D = 32'h704;
    tick();
    chk("hold_state", 32'(dut.state), 32'(HOLD));
    chk("hold_count", bubble_count, 32'd3);
    rst = 1'b1;
    tick();
    chk("hold_rst_state", 32'(dut.state), 32'(RUN));
    chk("hold_rst_pc_X", pc_X, RST_PC);
    chk("hold_rst_count", bubble_count, 32'd0);
    chk("hold_rst_valid_X", 32'(valid_X), 32'd0);
    rst = 1'b0;

    // Counter wrap from all-ones
    inst_D = LW_X5; pc_D = 32'h800;
    tick();
    inst_D = BEQ_5_6; pc_D = 32'h804;
    force dut.bubble_count = 32'hFFFF_FFFF;
    #1 release dut.bubble_count;
    #1 chk("wrap_preload", bubble_count, 32'hFFFF_FFFF);
    chk("wrap_stall", 32'(stall_D), 32'd1);
    tick();
    chk("wrap_count", bubble_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
